// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_i, wrapping modulo N. Produces a one-hot winner and its index.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  win_o,
   output logic [IW-1:0] win_idx_o,
   output logic          any_o
);

   always_comb begin
      int  cand;
      logic found;
      win_o     = '0;
      win_idx_o = '0;
      found     = 1'b0;
      cand      = 0;
      // Offsets 1..N visit every requester once, the previous winner last.
      for (int off = 1; off <= N; off++) begin
         cand = int'(last_i) + off;
         if (cand >= N) cand = cand - N;
         for (int j = 0; j < N; j++) begin
            if (!found && (j == cand) && req_i[j]) begin
               found     = 1'b1;
               win_o[j]  = 1'b1;
               win_idx_o = IW'(j);
            end
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add grant_cnt, per-requester 16-bit accepted-beat counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_data_in
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

   arb_state_t           state_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [IDX_W-1:0]     owner_q;
   logic [IDX_W-1:0]     last_winner_q;
   logic [CNT_W-1:0]     beat_cnt_q;
   logic [CNT_W-1:0]     beat_cnt_d;

   logic [NUM_REQ-1:0]   pick_win;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 owner_req;
   logic                 owner_last;
   logic                 wr_en;
   logic                 burst_done;
   logic [NUM_REQ-1:0]   ack_w;

   rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_rr_pick (
      .req_i     (req),
      .last_i    (last_winner_q),
      .win_o     (pick_win),
      .win_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   // grant_q is zero outside BURST, so masking gives the owner's signals directly.
   assign owner_req  = |(req & grant_q);
   assign owner_last = |(req_last & grant_q);
   assign wr_en      = (state_q == ARB_BURST) & owner_req & ~fifo_full;
   assign beat_cnt_d = beat_cnt_q + CNT_W'(1);
   assign burst_done = wr_en & (owner_last | (beat_cnt_d == BURST_END));
   assign ack_w      = wr_en ? grant_q : '0;

   assign ack        = ack_w;
   assign grant      = grant_q;
   assign busy       = (state_q == ARB_BURST);
   assign fifo_wr_en = wr_en;

   always_comb begin
      fifo_data_in = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         grant_q       <= '0;
         owner_q       <= '0;
         last_winner_q <= LAST_INIT;
         beat_cnt_q    <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_q    <= pick_win;
                  owner_q    <= pick_idx;
                  beat_cnt_q <= '0;
                  state_q    <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (wr_en) beat_cnt_q <= beat_cnt_d;
               // An abandoned burst (owner req low) ends like a completed one.
               if (burst_done || !owner_req) begin
                  state_q       <= ARB_IDLE;
                  grant_q       <= '0;
                  last_winner_q <= owner_q;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_cnt_q [NUM_REQ];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_w[i]) stat_cnt_q[i] <= stat_cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = stat_cnt_q[i];
   end
`endif

endmodule
